// File: rtl/clock_request_ctrl_if.sv
// Signal bundle between the clock-request controller, the power manager
// (switch commands, error clear, status) and the clock selector (req/ack).
// The controller connects through the slave modport; the environment that
// issues commands and answers requests uses the master modport.
interface clock_request_ctrl_if;
    logic       sel_in;
    logic       switch_valid;
    logic       switch_ready;
    logic       err_clr;
    logic       req_clk1;
    logic       ack_clk1;
    logic       req_clk2;
    logic       ack_clk2;
    logic       select;
    logic [1:0] active_clk;
    logic       busy;
    logic       timeout_err;

    modport slave (
        input  sel_in,
        input  switch_valid,
        input  err_clr,
        input  ack_clk1,
        input  ack_clk2,
        output switch_ready,
        output req_clk1,
        output req_clk2,
        output select,
        output active_clk,
        output busy,
        output timeout_err
    );

    modport master (
        output sel_in,
        output switch_valid,
        output err_clr,
        output ack_clk1,
        output ack_clk2,
        input  switch_ready,
        input  req_clk1,
        input  req_clk2,
        input  select,
        input  active_clk,
        input  busy,
        input  timeout_err
    );
endinterface

// File: rtl/clock_request_ctrl.sv
// Requester side of the clock-selector req/ack handshake. Runs on the
// always-on reference clock, accepts switch commands, and performs a
// break-before-make 4-phase handshake so req_clk1/req_clk2 are never high
// together. Acks are synchronized; every wait is bounded by a saturating
// counter that drives a sticky timeout error.
module clock_request_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_W   = 8,
    parameter bit RESET_SRC   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    clock_request_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_DROP  = 3'd2,
        ST_RAISE = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    localparam logic [TIMEOUT_W-1:0] CNT_ZERO = '0;
    localparam logic [TIMEOUT_W-1:0] CNT_ONE  = TIMEOUT_W'(1);
    localparam logic [TIMEOUT_W-1:0] CNT_MAX  = '1;
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = CNT_MAX - CNT_ONE;

    // One-hot encoding of a source for active_clk.
    function automatic logic [1:0] src_onehot(input logic src);
        return src ? 2'b10 : 2'b01;
    endfunction

    state_t                 state_r;
    logic [SYNC_STAGES-1:0] ack1_sync_r;
    logic [SYNC_STAGES-1:0] ack2_sync_r;
    logic [TIMEOUT_W-1:0]   wait_cnt_r;
    logic                   req_clk1_r;
    logic                   req_clk2_r;
    logic                   select_r;
    logic                   target_r;
    logic [1:0]             active_clk_r;
    logic                   busy_r;
    logic                   ready_r;
    logic                   timeout_err_r;

    logic                   ack1_s;
    logic                   ack2_s;
    logic                   old_ack_s;
    logic                   tgt_ack_s;
    logic                   init_ack_s;
    logic                   accept_s;
    logic                   waiting_s;
    logic                   wait_met_s;
    logic                   expire_s;
    logic [TIMEOUT_W-1:0]   wait_cnt_inc_s;

    // Multi-flop synchronizers for the asynchronous selector acks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack1_sync_r <= '0;
            ack2_sync_r <= '0;
        end else begin
            ack1_sync_r <= {ack1_sync_r[SYNC_STAGES-2:0], bus.ack_clk1};
            ack2_sync_r <= {ack2_sync_r[SYNC_STAGES-2:0], bus.ack_clk2};
        end
    end

    assign ack1_s     = ack1_sync_r[SYNC_STAGES-1];
    assign ack2_s     = ack2_sync_r[SYNC_STAGES-1];
    // While dropping, select still names the old source.
    assign old_ack_s  = select_r  ? ack2_s : ack1_s;
    assign tgt_ack_s  = target_r  ? ack2_s : ack1_s;
    assign init_ack_s = RESET_SRC ? ack2_s : ack1_s;
    assign accept_s   = bus.switch_valid & ready_r;

    // Saturating increment so the wait counter never wraps.
    assign wait_cnt_inc_s = (wait_cnt_r == CNT_MAX) ? CNT_MAX : (wait_cnt_r + CNT_ONE);

    // Decode whether the current state is waiting and whether its wait is satisfied.
    always_comb begin
        waiting_s  = 1'b0;
        wait_met_s = 1'b1;
        case (state_r)
            ST_INIT: begin
                waiting_s  = 1'b1;
                wait_met_s = init_ack_s;
            end
            ST_DROP: begin
                waiting_s  = 1'b1;
                wait_met_s = ~old_ack_s;
            end
            ST_RAISE: begin
                waiting_s  = 1'b1;
                wait_met_s = tgt_ack_s;
            end
            default: begin
                waiting_s  = 1'b0;
                wait_met_s = 1'b1;
            end
        endcase
    end

    // Expiry fires on the edge where the counter would reach all-ones while still unmet.
    assign expire_s = waiting_s & ~wait_met_s & (wait_cnt_r == CNT_LAST);

    // Handshake FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_INIT;
            wait_cnt_r    <= CNT_ZERO;
            req_clk1_r    <= 1'b0;
            req_clk2_r    <= 1'b0;
            select_r      <= RESET_SRC;
            target_r      <= RESET_SRC;
            active_clk_r  <= 2'b00;
            busy_r        <= 1'b1;
            ready_r       <= 1'b0;
            timeout_err_r <= 1'b0;
        end else if (expire_s) begin
            state_r       <= ST_ERR;
            wait_cnt_r    <= wait_cnt_inc_s;
            req_clk1_r    <= 1'b0;
            req_clk2_r    <= 1'b0;
            active_clk_r  <= 2'b00;
            busy_r        <= 1'b1;
            ready_r       <= 1'b0;
            timeout_err_r <= 1'b1;
        end else begin
            case (state_r)
                ST_INIT: begin
                    req_clk1_r <= ~RESET_SRC;
                    req_clk2_r <= RESET_SRC;
                    if (init_ack_s) begin
                        active_clk_r <= src_onehot(RESET_SRC);
                        state_r      <= ST_IDLE;
                        busy_r       <= 1'b0;
                        ready_r      <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_inc_s;
                    end
                end
                ST_IDLE: begin
                    if (accept_s && (bus.sel_in != select_r)) begin
                        target_r     <= bus.sel_in;
                        req_clk1_r   <= 1'b0;
                        req_clk2_r   <= 1'b0;
                        active_clk_r <= 2'b00;
                        wait_cnt_r   <= CNT_ZERO;
                        state_r      <= ST_DROP;
                        busy_r       <= 1'b1;
                        ready_r      <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (!old_ack_s) begin
                        req_clk1_r <= ~target_r;
                        req_clk2_r <= target_r;
                        select_r   <= target_r;
                        wait_cnt_r <= CNT_ZERO;
                        state_r    <= ST_RAISE;
                    end else begin
                        wait_cnt_r <= wait_cnt_inc_s;
                    end
                end
                ST_RAISE: begin
                    if (tgt_ack_s) begin
                        active_clk_r <= src_onehot(target_r);
                        state_r      <= ST_IDLE;
                        busy_r       <= 1'b0;
                        ready_r      <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_inc_s;
                    end
                end
                ST_ERR: begin
                    if (bus.err_clr) begin
                        timeout_err_r <= 1'b0;
                        select_r      <= RESET_SRC;
                        target_r      <= RESET_SRC;
                        wait_cnt_r    <= CNT_ZERO;
                        state_r       <= ST_INIT;
                    end else begin
                        state_r <= ST_ERR;
                    end
                end
                default: begin
                    req_clk1_r   <= 1'b0;
                    req_clk2_r   <= 1'b0;
                    active_clk_r <= 2'b00;
                    wait_cnt_r   <= CNT_ZERO;
                    busy_r       <= 1'b1;
                    ready_r      <= 1'b0;
                    state_r      <= ST_INIT;
                end
            endcase
        end
    end

    assign bus.req_clk1     = req_clk1_r;
    assign bus.req_clk2     = req_clk2_r;
    assign bus.select       = select_r;
    assign bus.active_clk   = active_clk_r;
    assign bus.busy         = busy_r;
    assign bus.switch_ready = ready_r;
    assign bus.timeout_err  = timeout_err_r;

endmodule

// File: doc/clock_request_ctrl.md
Name: clock_request_ctrl

Overview:
- Requester side of the clock-selector req/ack interface. Runs on an always-on reference clock.
- Accepts source-switch commands from the power manager over a valid/ready handshake.
- Drives req_clk1/req_clk2 as a break-before-make 4-phase handshake against ack_clk1/ack_clk2, so two requests are never asserted together.
- Synchronizes the acks, applies a timeout, and reports the active source and error status.

Parameters:
- SYNC_STAGES, 2, flops in each ack synchronizer (legal range 2..4).
- TIMEOUT_W, 8, width of the wait counter; timeout after 2^TIMEOUT_W-1 waiting cycles.
- RESET_SRC, 0, source requested after reset (0 = clk1, 1 = clk2).

Ports:
- clk  input  1  always-on reference clock; all logic is posedge.
- rst_n  input  1  asynchronous active-low reset.
- sel_in  input  1  requested source: 0 = clk1, 1 = clk2.
- switch_valid  input  1  switch command valid.
- switch_ready  output  1  command accepted when switch_valid & switch_ready.
- err_clr  input  1  one-cycle pulse; clears the error and restarts bring-up.
- req_clk1  output  1  request to selector for clk1; registered.
- ack_clk1  input  1  acknowledge from selector; asynchronous.
- req_clk2  output  1  request to selector for clk2; registered.
- ack_clk2  input  1  acknowledge from selector; asynchronous.
- select  output  1  selector select line: current target source; registered.
- active_clk  output  2  active source: 01 = clk1, 10 = clk2, 00 = none.
- busy  output  1  handshake in progress.
- timeout_err  output  1  sticky timeout flag.

Behaviour:
- Reset (async, rst_n low) forces the following:
  - state = INIT;
  - req_clk1 = req_clk2 = 0;
  - select = RESET_SRC;
  - active_clk = 00;
  - timeout_err = 0;
  - wait counter = 0;
  - all synchronizer flops = 0;
  - busy = 1 and switch_ready = 0, decoded from state.
- Acks pass through SYNC_STAGES flops; ack1_s and ack2_s are the synchronized acks. The FSM uses only the synced values.
- States: INIT, IDLE, DROP, RAISE, ERR.
- INIT:
  - First cycle after reset release: assert req of RESET_SRC, then wait for its ack_s = 1.
  - On ack: active_clk = that source, go to IDLE.
  - Counter expiry: go to ERR.
- IDLE:
  - switch_ready = 1, busy = 0.
  - On accept with sel_in == current source: no handshake, stay IDLE, outputs unchanged.
  - On accept with a different source: latch target, deassert current req next cycle, active_clk = 00, go to DROP.
- DROP:
  - Wait for the old source's ack_s = 0.
  - Then: assert target req, set select = target, go to RAISE.
  - Counter expiry: go to ERR.
- RAISE:
  - Wait for the target's ack_s = 1.
  - Then: active_clk = target one-hot, go to IDLE.
  - Counter expiry: go to ERR.
- ERR:
  - req_clk1 = req_clk2 = 0, active_clk = 00, timeout_err = 1, busy = 1, switch_ready = 0.
  - err_clr: clear timeout_err and go to INIT (re-requests RESET_SRC).
  - err_clr outside ERR has no effect.
- Wait counter:
  - Cleared on every entry to INIT, DROP or RAISE.
  - Increments each cycle the wait condition is unmet.
  - Expiry = counter reaching all-ones while still unmet; transition occurs on that edge.
  - Saturates; never wraps.
- Invariants:
  - req_clk1 & req_clk2 never both 1.
  - active_clk is never 11.
  - Outputs change only on posedge clk or async reset.
- switch_valid while not ready: ignored, not queued. The upstream must hold valid until ready.
- Minimum switch latency, accept edge to active_clk update: 2 + 2*SYNC_STAGES cycles, assuming immediate acks.
- Reset mid-handshake: all reqs drop asynchronously; the next bring-up restarts from INIT regardless of ack levels.

Test Plan:
- Reset release with a selector model acking after 3 cycles, RESET_SRC=0 -> req_clk1=1 the cycle after release; active_clk=01 and busy=0 after ack1_s rises; req_clk2 stays 0.
- From active clk1, sel_in=1 + valid -> req_clk1 falls next cycle; req_clk2 rises only after ack1_s=0; select=1; active_clk=10 at 2+2*SYNC_STAGES cycles with zero-delay acks.
- In IDLE on clk2, sel_in=1 + valid -> accepted in 1 cycle, no req toggles, busy stays 0.
- ack_clk2 stuck at 0 during RAISE -> after 255 cycles (TIMEOUT_W=8): timeout_err=1, both reqs 0, active_clk=00. Then err_clr pulse -> INIT and clk1 re-requested.
- switch_valid held while busy=1 -> no accept until IDLE; exactly one switch performed.
- rst_n asserted in DROP and RAISE states -> reqs drop to 0 the same instant; clean INIT bring-up after release; assertion that reqs are never both high throughout the run.
